// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the DMA/debug loader, the data memory
// and the dmem_arbiter that shares the memory port among them.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        cpu_err;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dma_err;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [15:0] stall_count;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
    output dma_gnt, dma_rvalid, dma_rdata, dma_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output stall_count
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
    input  dma_gnt, dma_rvalid, dma_rdata, dma_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  stall_count
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Fixed-priority data-memory arbiter (CPU over DMA) with a starvation bound
// that forces the DMA through, plus registered per-requester responses.
module dmem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_LIMIT = 64
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [31:0] ADDR_LIM   = 32'(ADDR_LIMIT);

  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic        cpu_err_q, cpu_err_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        dma_rvalid_q, dma_rvalid_d;
  logic        dma_err_q, dma_err_d;
  logic [31:0] dma_rdata_q, dma_rdata_d;

  logic        gnt_cpu, gnt_dma;
  logic        cpu_legal, dma_legal, sel_legal;
  logic        sel_we;
  logic [31:0] sel_addr, sel_wdata;
  logic        cpu_stall;

  // Stage 0: zero-cycle grant decision and memory port mux
  always_comb begin
    cpu_legal = (bus.cpu_addr[1:0] == 2'b00) && (bus.cpu_addr < ADDR_LIM);
    dma_legal = (bus.dma_addr[1:0] == 2'b00) && (bus.dma_addr < ADDR_LIM);

    gnt_cpu = 1'b0;
    gnt_dma = 1'b0;
    if (!rst) begin
      if (bus.cpu_req && bus.dma_req) begin
        if (starve_cnt_q == STARVE_LIM) gnt_dma = 1'b1;
        else                            gnt_cpu = 1'b1;
      end else begin
        gnt_cpu = bus.cpu_req;
        gnt_dma = bus.dma_req;
      end
    end
    cpu_stall = bus.cpu_req && gnt_dma;

    sel_we    = 1'b0;
    sel_addr  = 32'd0;
    sel_wdata = 32'd0;
    sel_legal = 1'b0;
    if (gnt_cpu) begin
      sel_we    = bus.cpu_we;
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
      sel_legal = cpu_legal;
    end else if (gnt_dma) begin
      sel_we    = bus.dma_we;
      sel_addr  = bus.dma_addr;
      sel_wdata = bus.dma_wdata;
      sel_legal = dma_legal;
    end
  end

  assign bus.cpu_stall = cpu_stall;
  assign bus.dma_gnt   = gnt_dma;
  assign bus.mem_en    = sel_legal;
  assign bus.mem_we    = sel_legal && sel_we;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

  // Stage 0 -> 1: next-state of counters and response registers
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (gnt_dma || !bus.dma_req)     starve_cnt_d = 4'd0;
    else if (starve_cnt_q < STARVE_LIM) starve_cnt_d = starve_cnt_q + 4'd1;

    stall_count_d = stall_count_q;
    if (cpu_stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;

    cpu_rvalid_d = gnt_cpu && !bus.cpu_we && cpu_legal;
    cpu_err_d    = gnt_cpu && !cpu_legal;
    cpu_rdata_d  = cpu_rvalid_d ? bus.mem_rdata : cpu_rdata_q;

    dma_rvalid_d = gnt_dma && !bus.dma_we && dma_legal;
    dma_err_d    = gnt_dma && !dma_legal;
    dma_rdata_d  = dma_rvalid_d ? bus.mem_rdata : dma_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q  <= 4'd0;
      stall_count_q <= 16'd0;
      cpu_rvalid_q  <= 1'b0;
      cpu_err_q     <= 1'b0;
      cpu_rdata_q   <= 32'd0;
      dma_rvalid_q  <= 1'b0;
      dma_err_q     <= 1'b0;
      dma_rdata_q   <= 32'd0;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      stall_count_q <= stall_count_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      cpu_err_q     <= cpu_err_d;
      cpu_rdata_q   <= cpu_rdata_d;
      dma_rvalid_q  <= dma_rvalid_d;
      dma_err_q     <= dma_err_d;
      dma_rdata_q   <= dma_rdata_d;
    end
  end

  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.cpu_err     = cpu_err_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.dma_rvalid  = dma_rvalid_q;
  assign bus.dma_err     = dma_err_q;
  assign bus.dma_rdata   = dma_rdata_q;
  assign bus.stall_count = stall_count_q;

endmodule
